// File: rtl/intt_radix8_pipe.sv
// ---------------------------------------------------------------------------
// intt_radix8_pipe
//
// Purpose:
//   8-point inverse NTT over Z_Q with n^-1 scaling and psi^-1 post-twist, for
//   the INTT return path of the polynomial multiplier:
//
//     y[j] = n_inv * p[j] * SUM_k x[k] * W^((j*k) mod 8)   mod Q
//
//   Three registered Gentleman-Sande (decimation-in-frequency) radix-2 stages
//   produce the transform in bit-reversed order. The fourth registered stage
//   undoes that order by wiring and applies n_inv and p[j].
//
//   Every frame carries its own twiddles, post-twist factors and scale factor
//   down the pipe, so these inputs may change on every accepted frame.
//
// Ports:
//   clk                      rising-edge clock
//   rst_n                    asynchronous active-low reset
//   in_valid / in_ready      input handshake (in_ready never depends on in_valid)
//   input_1..input_8         coefficients x[0..7], each < Q
//   w_inv_1_8..w_inv_3_8     W^1..W^3 of the inverse primitive 8th root W
//   psi_inv_1..psi_inv_8     post-twist factors p[0..7], each < Q
//   n_inv                    scale factor (8^-1 mod Q in normal use)
//   out_valid / out_ready    output handshake
//   output_1..output_8       results y[0..7], each in [0,Q)
//   busy                     some pipeline stage holds a valid frame
// ---------------------------------------------------------------------------
module intt_radix8_pipe #(
    parameter int WIDTH = 18,
    parameter int Q     = 12289
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_1,
    input  logic [WIDTH-1:0] input_2,
    input  logic [WIDTH-1:0] input_3,
    input  logic [WIDTH-1:0] input_4,
    input  logic [WIDTH-1:0] input_5,
    input  logic [WIDTH-1:0] input_6,
    input  logic [WIDTH-1:0] input_7,
    input  logic [WIDTH-1:0] input_8,
    input  logic [WIDTH-1:0] w_inv_1_8,
    input  logic [WIDTH-1:0] w_inv_2_8,
    input  logic [WIDTH-1:0] w_inv_3_8,
    input  logic [WIDTH-1:0] psi_inv_1,
    input  logic [WIDTH-1:0] psi_inv_2,
    input  logic [WIDTH-1:0] psi_inv_3,
    input  logic [WIDTH-1:0] psi_inv_4,
    input  logic [WIDTH-1:0] psi_inv_5,
    input  logic [WIDTH-1:0] psi_inv_6,
    input  logic [WIDTH-1:0] psi_inv_7,
    input  logic [WIDTH-1:0] psi_inv_8,
    input  logic [WIDTH-1:0] n_inv,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] output_1,
    output logic [WIDTH-1:0] output_2,
    output logic [WIDTH-1:0] output_3,
    output logic [WIDTH-1:0] output_4,
    output logic [WIDTH-1:0] output_5,
    output logic [WIDTH-1:0] output_6,
    output logic [WIDTH-1:0] output_7,
    output logic [WIDTH-1:0] output_8,
    output logic             busy
);

    typedef logic [WIDTH-1:0]   word_t;
    typedef logic [WIDTH:0]     ext_t;    // one guard bit for a+b and a+Q-b
    typedef logic [2*WIDTH-1:0] dword_t;  // full product width

    localparam ext_t   Q_EXT = ext_t'(Q);
    localparam dword_t Q_DW  = dword_t'(Q);
    localparam word_t  ONE   = word_t'(1);

    // -----------------------------------------------------------------------
    // Modular arithmetic; operands are canonical, results are canonical.
    // -----------------------------------------------------------------------
    function automatic word_t add_mod(input word_t a, input word_t b);
        ext_t s;
        s = ext_t'(a) + ext_t'(b);
        if (s >= Q_EXT) begin
            s = s - Q_EXT;
        end
        return word_t'(s);
    endfunction

    function automatic word_t sub_mod(input word_t a, input word_t b);
        if (a >= b) begin
            return a - b;
        end
        return word_t'(ext_t'(a) + Q_EXT - ext_t'(b));
    endfunction

    function automatic word_t mul_mod(input word_t a, input word_t b);
        dword_t p;
        p = dword_t'(a) * dword_t'(b);
        return word_t'(p % Q_DW);
    endfunction

    // Position of natural-order result j in the DIF output.
    function automatic logic [2:0] bitrev3(input logic [2:0] i);
        return {i[0], i[1], i[2]};
    endfunction

    // -----------------------------------------------------------------------
    // Port bundling
    // -----------------------------------------------------------------------
    word_t x_in   [8];
    word_t psi_in [8];
    word_t tw1    [4];  // stage-1 twiddles W^0..W^3

    always_comb begin
        x_in[0]   = input_1;   x_in[1]   = input_2;
        x_in[2]   = input_3;   x_in[3]   = input_4;
        x_in[4]   = input_5;   x_in[5]   = input_6;
        x_in[6]   = input_7;   x_in[7]   = input_8;
        psi_in[0] = psi_inv_1; psi_in[1] = psi_inv_2;
        psi_in[2] = psi_inv_3; psi_in[3] = psi_inv_4;
        psi_in[4] = psi_inv_5; psi_in[5] = psi_inv_6;
        psi_in[6] = psi_inv_7; psi_in[7] = psi_inv_8;
        tw1[0]    = ONE;
        tw1[1]    = w_inv_1_8;
        tw1[2]    = w_inv_2_8;
        tw1[3]    = w_inv_3_8;
    end

    // -----------------------------------------------------------------------
    // Pipeline state
    // -----------------------------------------------------------------------
    logic  s1_v, s2_v, s3_v, s4_v;
    word_t s1_d [8];
    word_t s2_d [8];
    word_t s3_d [8];
    word_t s4_d [8];
    word_t s1_p [8];
    word_t s2_p [8];
    word_t s3_p [8];
    word_t s1_w2;               // W^2 is the only twiddle stage 2 needs
    word_t s1_n, s2_n, s3_n;

    // The whole pipe advances in lock-step unless a valid result is waiting
    // on the sink; bubbles therefore never block intake.
    logic adv;
    logic accept;

    assign adv      = !(s4_v && !out_ready);
    assign in_ready = adv;
    assign accept   = in_valid && adv;

    // -----------------------------------------------------------------------
    // Stage 1: span-4 butterflies, twiddles W^0..W^3 on the difference leg.
    // -----------------------------------------------------------------------
    word_t t1 [8];

    // NOTE: each always_comb writes every element of its result array on every
    // pass, so no storage (latch) can be inferred for any of them.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            t1[k]     = add_mod(x_in[k], x_in[k+4]);
            t1[k + 4] = mul_mod(sub_mod(x_in[k], x_in[k+4]), tw1[k]);
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: span-2 butterflies inside each half, twiddles W^0 and W^2.
    // -----------------------------------------------------------------------
    word_t t2 [8];

    always_comb begin
        for (int b = 0; b < 8; b += 4) begin
            t2[b]     = add_mod(s1_d[b], s1_d[b+2]);
            t2[b + 2] = sub_mod(s1_d[b], s1_d[b+2]);
            t2[b + 1] = add_mod(s1_d[b+1], s1_d[b+3]);
            t2[b + 3] = mul_mod(sub_mod(s1_d[b+1], s1_d[b+3]), s1_w2);
        end
    end

    // -----------------------------------------------------------------------
    // Stage 3: span-1 butterflies; the twiddle is W^0 throughout.
    // -----------------------------------------------------------------------
    word_t t3 [8];

    always_comb begin
        for (int i = 0; i < 8; i += 2) begin
            t3[i]     = add_mod(s2_d[i], s2_d[i+1]);
            t3[i + 1] = sub_mod(s2_d[i], s2_d[i+1]);
        end
    end

    // -----------------------------------------------------------------------
    // Stage 4: bit-reverse reorder, then x n_inv x p[j].
    // -----------------------------------------------------------------------
    word_t t4 [8];

    always_comb begin
        for (int j = 0; j < 8; j++) begin
            t4[j] = mul_mod(mul_mod(s3_d[bitrev3(3'(j))], s3_n), s3_p[j]);
        end
    end

    // -----------------------------------------------------------------------
    // Registers. Data moves with adv regardless of the valid bit; only the
    // valid bits decide what is a frame and what is a bubble.
    // -----------------------------------------------------------------------
    // NOTE: the data arrays are reset too, because the outputs must read zero
    // during and straight after reset; an unreset array would expose stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v  <= 1'b0;
            s2_v  <= 1'b0;
            s3_v  <= 1'b0;
            s4_v  <= 1'b0;
            s1_w2 <= '0;
            s1_n  <= '0;
            s2_n  <= '0;
            s3_n  <= '0;
            for (int i = 0; i < 8; i++) begin
                s1_d[i] <= '0;
                s2_d[i] <= '0;
                s3_d[i] <= '0;
                s4_d[i] <= '0;
                s1_p[i] <= '0;
                s2_p[i] <= '0;
                s3_p[i] <= '0;
            end
        end else if (adv) begin
            s1_v  <= accept;
            s2_v  <= s1_v;
            s3_v  <= s2_v;
            s4_v  <= s3_v;
            s1_w2 <= w_inv_2_8;
            s1_n  <= n_inv;
            s2_n  <= s1_n;
            s3_n  <= s2_n;
            for (int i = 0; i < 8; i++) begin
                s1_d[i] <= t1[i];
                s2_d[i] <= t2[i];
                s3_d[i] <= t3[i];
                s4_d[i] <= t4[i];
                s1_p[i] <= psi_in[i];
                s2_p[i] <= s1_p[i];
                s3_p[i] <= s2_p[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign out_valid = s4_v;
    assign busy      = s1_v | s2_v | s3_v | s4_v;

    assign output_1 = s4_d[0];
    assign output_2 = s4_d[1];
    assign output_3 = s4_d[2];
    assign output_4 = s4_d[3];
    assign output_5 = s4_d[4];
    assign output_6 = s4_d[5];
    assign output_7 = s4_d[6];
    assign output_8 = s4_d[7];

endmodule
